// File: rtl/bram_arb_pkg.sv
// Shared definitions for the two-requester block RAM arbiter: state encoding,
// requester indices and the lock counter type.
package bram_arb_pkg;

  typedef logic [1:0] state_t;

  localparam state_t IDLE = 2'd0;
  localparam state_t OWN0 = 2'd1;
  localparam state_t OWN1 = 2'd2;

  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;

  localparam int unsigned LOCK_CNT_W = 8;
  typedef logic [LOCK_CNT_W-1:0] lock_cnt_t;

  function automatic lock_cnt_t lock_cnt_inc(input lock_cnt_t c);
    return (c == '1) ? c : c + 1'b1;
  endfunction

endpackage

// File: rtl/bram_arb_if.sv
// Requester-side bus of the block RAM arbiter: both requesters plus shared
// read data. master = requester side, slave = arbiter side.
interface bram_arb_if #(
  parameter int unsigned ADDR_WIDTH = 14
) ();

  logic                  m0_req;
  logic                  m0_lock;
  logic [3:0]            m0_we;
  logic [ADDR_WIDTH-1:0] m0_addr;
  logic [31:0]           m0_wdata;
  logic                  m0_gnt;
  logic                  m0_rvalid;

  logic                  m1_req;
  logic                  m1_lock;
  logic [3:0]            m1_we;
  logic [ADDR_WIDTH-1:0] m1_addr;
  logic [31:0]           m1_wdata;
  logic                  m1_gnt;
  logic                  m1_rvalid;

  logic [31:0]           rdata;

  modport master (
    output m0_req, m0_lock, m0_we, m0_addr, m0_wdata,
    output m1_req, m1_lock, m1_we, m1_addr, m1_wdata,
    input  m0_gnt, m0_rvalid, m1_gnt, m1_rvalid, rdata
  );

  modport slave (
    input  m0_req, m0_lock, m0_we, m0_addr, m0_wdata,
    input  m1_req, m1_lock, m1_we, m1_addr, m1_wdata,
    output m0_gnt, m0_rvalid, m1_gnt, m1_rvalid, rdata
  );

endinterface

// File: rtl/bram_arb_pick.sv
// Two-way priority selector used for IDLE arbitration.
// prio = 0 favours M0 on contention, prio = 1 favours M1.
module bram_arb_pick
  import bram_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       prio,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = '0;
    if (req[M0] && (!req[M1] || !prio)) begin
      gnt[M0] = 1'b1;
    end else if (req[M1]) begin
      gnt[M1] = 1'b1;
    end
  end

endmodule

// File: rtl/bram_arbiter.sv
// Two-requester arbiter for the 32-bit block RAM with locked bursts.
// Define BRAM_ARB_RR_EN for round-robin IDLE arbitration (default: M0 fixed priority).
module bram_arbiter
  import bram_arb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 14,
  parameter int unsigned MAX_LOCK   = 16
) (
  input  logic                  clka,
  input  logic                  rst,
  bram_arb_if.slave             bus,
  output logic [ADDR_WIDTH-1:0] ram_addra,
  output logic [31:0]           ram_dina,
  output logic [3:0]            ram_wea,
  output logic [ADDR_WIDTH-1:0] ram_addrb,
  input  logic [31:0]           ram_doutb
);

  localparam lock_cnt_t MAX_CNT = lock_cnt_t'(MAX_LOCK);

  state_t    state_q, state_d;
  lock_cnt_t cnt_q, cnt_d, cnt_nxt;
  logic      forced_q, forced_d;
  logic      released_q, released_d;
  logic      rv0_q, rv1_q;
  logic      own;
  logic      base_prio, prio;
  logic [1:0] req, lock, pick_gnt, gnt;

  assign req  = {bus.m1_req,  bus.m0_req};
  assign lock = {bus.m1_lock, bus.m0_lock};

`ifdef BRAM_ARB_RR_EN
  logic rr_q;

  always_ff @(posedge clka) begin
    if (rst) begin
      rr_q <= 1'b0;
    end else if (state_q == IDLE && gnt != 2'b00) begin
      rr_q <= gnt[M0];
    end
  end

  assign base_prio = rr_q;
`else
  assign base_prio = 1'b0;
`endif

  // A forced release hands the next IDLE slot to the side that was kept waiting.
  assign prio = forced_q ? ~released_q : base_prio;

  bram_arb_pick u_pick (
    .req  (req),
    .prio (prio),
    .gnt  (pick_gnt)
  );

  always_comb begin
    gnt = '0;
    if (!rst) begin
      case (state_q)
        IDLE:    gnt = pick_gnt;
        OWN0:    gnt[M0] = req[M0];
        OWN1:    gnt[M1] = req[M1];
        default: gnt = '0;
      endcase
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    forced_d   = forced_q;
    released_d = released_q;
    own        = (state_q == OWN1);
    cnt_nxt    = lock_cnt_inc(cnt_q);
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (gnt != 2'b00) begin
          forced_d = 1'b0;
          if (gnt[M0] && lock[M0]) begin
            state_d = OWN0;
            cnt_d   = lock_cnt_t'(1);
          end else if (gnt[M1] && lock[M1]) begin
            state_d = OWN1;
            cnt_d   = lock_cnt_t'(1);
          end
        end
      end
      OWN0, OWN1: begin
        if (!req[own] || !lock[own]) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_nxt >= MAX_CNT) begin
          state_d    = IDLE;
          cnt_d      = '0;
          forced_d   = 1'b1;
          released_d = own;
        end else begin
          cnt_d = cnt_nxt;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clka) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      forced_q   <= 1'b0;
      released_q <= 1'b0;
      rv0_q      <= 1'b0;
      rv1_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      forced_q   <= forced_d;
      released_q <= released_d;
      rv0_q      <= gnt[M0] && (bus.m0_we == 4'b0000);
      rv1_q      <= gnt[M1] && (bus.m1_we == 4'b0000);
    end
  end

  always_comb begin
    ram_addra = gnt[M1] ? bus.m1_addr  : bus.m0_addr;
    ram_dina  = gnt[M1] ? bus.m1_wdata : bus.m0_wdata;
    ram_addrb = ram_addra;
    if (gnt[M0]) begin
      ram_wea = bus.m0_we;
    end else if (gnt[M1]) begin
      ram_wea = bus.m1_we;
    end else begin
      ram_wea = '0;
    end
  end

  assign bus.m0_gnt    = gnt[M0];
  assign bus.m1_gnt    = gnt[M1];
  // rvalid is masked by rst so a read outstanding when reset arrives is dropped at once.
  assign bus.m0_rvalid = rv0_q & ~rst;
  assign bus.m1_rvalid = rv1_q & ~rst;
  assign bus.rdata     = ram_doutb;

endmodule

// File: tb/tb_bram_arbiter.sv
// Directed bench for bram_arbiter with a behavioural byte-enabled block RAM.
module tb_bram_arbiter;

  localparam int unsigned AW = 14;
`ifdef BRAM_ARB_RR_EN
  localparam logic RR = 1'b1;
`else
  localparam logic RR = 1'b0;
`endif

  logic          clk;
  logic          rst;
  logic [AW-1:0] ram_addra, ram_addrb;
  logic [31:0]   ram_dina, ram_doutb;
  logic [3:0]    ram_wea;
  logic [31:0]   mem [0:(1<<AW)-1];

  int checks = 0;
  int errors = 0;

  bram_arb_if #(.ADDR_WIDTH(AW)) bus ();

  bram_arbiter #(.ADDR_WIDTH(AW), .MAX_LOCK(4)) dut (
    .clka      (clk),
    .rst       (rst),
    .bus       (bus),
    .ram_addra (ram_addra),
    .ram_dina  (ram_dina),
    .ram_wea   (ram_wea),
    .ram_addrb (ram_addrb),
    .ram_doutb (ram_doutb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (ram_wea[b]) mem[ram_addra][b*8 +: 8] <= ram_dina[b*8 +: 8];
    end
    ram_doutb <= mem[ram_addrb];
  end

  typedef struct {
    logic        rst;
    logic        q0;
    logic [3:0]  w0;
    logic [13:0] a0;
    logic [31:0] d0;
    logic        q1;
    logic [3:0]  w1;
    logic [13:0] a1;
    logic [31:0] d1;
    logic        g0;
    logic        g1;
    logic [3:0]  wea;
    logic [13:0] addr;
    logic        rv0;
    logic        rv1;
    logic [31:0] rd;
  } vec_t;

  vec_t vt[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic q0, input logic l0, input logic [3:0] w0, input logic [13:0] a0,
                       input logic [31:0] d0, input logic q1, input logic l1, input logic [3:0] w1,
                       input logic [13:0] a1, input logic [31:0] d1);
    bus.m0_req = q0; bus.m0_lock = l0; bus.m0_we = w0; bus.m0_addr = a0; bus.m0_wdata = d0;
    bus.m1_req = q1; bus.m1_lock = l1; bus.m1_we = w1; bus.m1_addr = a1; bus.m1_wdata = d1;
  endtask

  function automatic vec_t v(logic r, logic q0, logic [3:0] w0, logic [13:0] a0, logic [31:0] d0,
                             logic q1, logic [3:0] w1, logic [13:0] a1, logic [31:0] d1,
                             logic g0, logic g1, logic [3:0] wea, logic [13:0] addr,
                             logic rv0, logic rv1, logic [31:0] rd);
    vec_t x;
    x.rst = r; x.q0 = q0; x.w0 = w0; x.a0 = a0; x.d0 = d0;
    x.q1 = q1; x.w1 = w1; x.a1 = a1; x.d1 = d1;
    x.g0 = g0; x.g1 = g1; x.wea = wea; x.addr = addr;
    x.rv0 = rv0; x.rv1 = rv1; x.rd = rd;
    return x;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int   k;
    int   who;
    logic m0_done;
    logic exp_g0, prev_g0;
    int   exp_who [7] = '{1, 1, 1, 1, 0, 1, 1};
    logic [13:0] exp_a [7] = '{14'h100, 14'h101, 14'h102, 14'h103, 14'h010, 14'h104, 14'h105};

    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    //      rst q0 w0    a0      d0            q1 w1    a1      d1            g0 g1 wea   addr    rv0 rv1 rd
    vt.push_back(v(1, 1, 4'hF, 14'h10, 32'hDEADBEEF, 1, 4'hF, 14'h20, 32'hAABBCCDD, 0, 0, 4'h0, 14'h0,  0, 0, 32'h0));
    vt.push_back(v(1, 1, 4'hF, 14'h10, 32'hDEADBEEF, 1, 4'hF, 14'h20, 32'hAABBCCDD, 0, 0, 4'h0, 14'h0,  0, 0, 32'h0));
    vt.push_back(v(1, 1, 4'hF, 14'h10, 32'hDEADBEEF, 1, 4'hF, 14'h20, 32'hAABBCCDD, 0, 0, 4'h0, 14'h0,  0, 0, 32'h0));
    vt.push_back(v(0, 1, 4'hF, 14'h10, 32'hDEADBEEF, 0, 4'h0, 14'h0,  32'h0,        1, 0, 4'hF, 14'h10, 0, 0, 32'h0));
    vt.push_back(v(0, 1, 4'h0, 14'h10, 32'h0,        0, 4'h0, 14'h0,  32'h0,        1, 0, 4'h0, 14'h10, 0, 0, 32'h0));
    vt.push_back(v(0, 0, 4'h0, 14'h0,  32'h0,        0, 4'h0, 14'h0,  32'h0,        0, 0, 4'h0, 14'h0,  1, 0, 32'hDEADBEEF));
    vt.push_back(v(0, 1, 4'hF, 14'h20, 32'h11223344, 0, 4'h0, 14'h0,  32'h0,        1, 0, 4'hF, 14'h20, 0, 0, 32'h0));
    vt.push_back(v(0, 0, 4'h0, 14'h0,  32'h0,        1, 4'h5, 14'h20, 32'hAABBCCDD, 0, 1, 4'h5, 14'h20, 0, 0, 32'h0));
    vt.push_back(v(0, 0, 4'h0, 14'h0,  32'h0,        1, 4'h0, 14'h20, 32'h0,        0, 1, 4'h0, 14'h20, 0, 0, 32'h0));
    vt.push_back(v(0, 0, 4'h0, 14'h0,  32'h0,        0, 4'h0, 14'h0,  32'h0,        0, 0, 4'h0, 14'h0,  0, 1, 32'h11BB33DD));
    vt.push_back(v(0, 1, 4'hF, 14'h30, 32'hCAFEF00D, 0, 4'h0, 14'h0,  32'h0,        1, 0, 4'hF, 14'h30, 0, 0, 32'h0));
    vt.push_back(v(0, 0, 4'h0, 14'h0,  32'h0,        1, 4'h0, 14'h30, 32'h0,        0, 1, 4'h0, 14'h30, 0, 0, 32'h0));
    vt.push_back(v(0, 0, 4'h0, 14'h0,  32'h0,        0, 4'h0, 14'h0,  32'h0,        0, 0, 4'h0, 14'h0,  0, 1, 32'hCAFEF00D));
    vt.push_back(v(0, 1, 4'h0, 14'h10, 32'h0,        0, 4'h0, 14'h0,  32'h0,        1, 0, 4'h0, 14'h10, 0, 0, 32'h0));
    vt.push_back(v(0, 1, 4'h0, 14'h30, 32'h0,        0, 4'h0, 14'h0,  32'h0,        1, 0, 4'h0, 14'h30, 1, 0, 32'hDEADBEEF));
    vt.push_back(v(0, 0, 4'h0, 14'h0,  32'h0,        0, 4'h0, 14'h0,  32'h0,        0, 0, 4'h0, 14'h0,  1, 0, 32'hCAFEF00D));
    vt.push_back(v(0, 0, 4'h0, 14'h0,  32'h0,        1, 4'h0, 14'h20, 32'h0,        0, 1, 4'h0, 14'h20, 0, 0, 32'h0));
    vt.push_back(v(0, 0, 4'h0, 14'h0,  32'h0,        0, 4'h0, 14'h0,  32'h0,        0, 0, 4'h0, 14'h0,  0, 1, 32'h11BB33DD));

    for (int i = 0; i < vt.size(); i++) begin
      @(posedge clk); #1;
      rst = vt[i].rst;
      drive(vt[i].q0, 1'b0, vt[i].w0, vt[i].a0, vt[i].d0, vt[i].q1, 1'b0, vt[i].w1, vt[i].a1, vt[i].d1);
      #4;
      chk($sformatf("v%0d m0_gnt", i), {31'b0, bus.m0_gnt}, {31'b0, vt[i].g0});
      chk($sformatf("v%0d m1_gnt", i), {31'b0, bus.m1_gnt}, {31'b0, vt[i].g1});
      chk($sformatf("v%0d ram_wea", i), {28'b0, ram_wea}, {28'b0, vt[i].wea});
      chk($sformatf("v%0d m0_rvalid", i), {31'b0, bus.m0_rvalid}, {31'b0, vt[i].rv0});
      chk($sformatf("v%0d m1_rvalid", i), {31'b0, bus.m1_rvalid}, {31'b0, vt[i].rv1});
      if (vt[i].g0 || vt[i].g1) begin
        chk($sformatf("v%0d ram_addra", i), {18'b0, ram_addra}, {18'b0, vt[i].addr});
        chk($sformatf("v%0d ram_addrb", i), {18'b0, ram_addrb}, {18'b0, vt[i].addr});
      end
      if (vt[i].rv0 || vt[i].rv1) chk($sformatf("v%0d rdata", i), bus.rdata, vt[i].rd);
    end

    // Contention without lock: RR alternates starting at M0, fixed priority always M0.
    prev_g0 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      drive(1, 0, 4'h0, 14'h10, 32'h0, 1, 0, 4'h0, 14'h20, 32'h0);
      #4;
      exp_g0 = RR ? (i % 2 == 0) : 1'b1;
      chk($sformatf("cont%0d m0_gnt", i), {31'b0, bus.m0_gnt}, {31'b0, exp_g0});
      chk($sformatf("cont%0d m1_gnt", i), {31'b0, bus.m1_gnt}, {31'b0, ~exp_g0});
      if (i > 0) begin
        chk($sformatf("cont%0d m0_rvalid", i), {31'b0, bus.m0_rvalid}, {31'b0, prev_g0});
        chk($sformatf("cont%0d m1_rvalid", i), {31'b0, bus.m1_rvalid}, {31'b0, ~prev_g0});
      end
      prev_g0 = exp_g0;
    end

    // Preload the burst window through M0 writes.
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      drive(1, 0, 4'hF, 14'h100 + 14'(i), 32'h5000_0100 + i, 0, 0, 4'h0, 14'h0, 32'h0);
      #4;
      chk($sformatf("pre%0d m0_gnt", i), {31'b0, bus.m0_gnt}, 32'd1);
    end

    // Locked burst, MAX_LOCK=4: M1 x4, forced release, M0 once, M1 resumes at 0x104.
    k = 0;
    m0_done = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      drive((c >= 1) && !m0_done, 0, 4'h0, 14'h010, 32'h0,
            k < 6, 1, 4'h0, 14'h100 + 14'(k), 32'h0);
      #4;
      who = bus.m1_gnt ? 1 : (bus.m0_gnt ? 0 : 2);
      if (c < 7) begin
        chk($sformatf("lock%0d owner", c), who, exp_who[c]);
        chk($sformatf("lock%0d addr", c), {18'b0, ram_addra}, {18'b0, exp_a[c]});
      end else begin
        chk($sformatf("lock%0d owner", c), who, 2);
      end
      if (c > 0) begin
        chk($sformatf("lock%0d m1_rvalid", c), {31'b0, bus.m1_rvalid}, (exp_who[c-1] == 1) ? 32'd1 : 32'd0);
        chk($sformatf("lock%0d m0_rvalid", c), {31'b0, bus.m0_rvalid}, (exp_who[c-1] == 0) ? 32'd1 : 32'd0);
        if (exp_who[c-1] == 1)
          chk($sformatf("lock%0d rdata", c), bus.rdata, 32'h5000_0000 + {18'b0, exp_a[c-1]});
      end
      if (bus.m1_gnt) k++;
      if (bus.m0_gnt) m0_done = 1'b1;
    end

    // Reset arriving with an M0 read outstanding drops the read.
    @(posedge clk); #1;
    drive(1, 0, 4'h0, 14'h10, 32'h0, 0, 0, 4'h0, 14'h0, 32'h0);
    #4;
    chk("rstrd grant", {31'b0, bus.m0_gnt}, 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    drive(0, 0, 4'h0, 14'h0, 32'h0, 0, 0, 4'h0, 14'h0, 32'h0);
    #4;
    chk("rstrd rvalid N+1", {31'b0, bus.m0_rvalid}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    #4;
    chk("rstrd rvalid N+2", {31'b0, bus.m0_rvalid}, 32'd0);
    @(posedge clk); #5;
    chk("rstrd rvalid N+3", {31'b0, bus.m0_rvalid}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bram_arbiter.md
# bram_arbiter

Two-requester arbiter for the 32-bit program/data block RAM (one byte-enabled write port, one registered read port, 1-cycle read latency). It sits between the CPU bus-side RAM interface (M0) and the DMA/asset loader (M1), granting at most one access per cycle and routing read data back to the owner. Supports short locked bursts so a loader can stream consecutive words without interleaving.

## Interface
- ADDR_WIDTH, 14, word address width; matches the RAM depth.
- MAX_LOCK, 16, maximum consecutive grants a locked requester may hold before forced release; range 2..255.

- clka  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- m0_req / m1_req  in  1  access request; held until granted.
- m0_lock / m1_lock  in  1  requester wants to keep ownership after this access.
- m0_we / m1_we  in  4  byte write enables; 4'b0000 means read.
- m0_addr / m1_addr  in  ADDR_WIDTH  word address.
- m0_wdata / m1_wdata  in  32  write data.
- m0_gnt / m1_gnt  out  1  combinational grant; access happens in cycle where req && gnt.
- m0_rvalid / m1_rvalid  out  1  registered; read data valid for that requester.
- rdata  out  32  shared read data, wired from ram_doutb.
- ram_addra  out  ADDR_WIDTH  RAM write address.
- ram_dina  out  32  RAM write data.
- ram_wea  out  4  RAM byte write enables.
- ram_addrb  out  ADDR_WIDTH  RAM read address.
- ram_doutb  in  32  RAM registered read data.

## Operation
- One access per cycle. Winner's addr drives both ram_addra and ram_addrb; winner's we/wdata drive ram_wea/ram_dina. No winner: ram_wea = 0, addresses/data hold the M0 values (don't-care).
- A granted read (we == 0) sets that requester's rvalid in the next cycle; rdata is valid that same cycle. Granted writes produce no rvalid.
- FSM states: IDLE, OWN0, OWN1. Reset → IDLE.
  - IDLE: arbitrate among requesters (see Configuration). Grant with lock=1 → OWNx, lock counter loaded to 1.
  - OWNx: only Mx may be granted; other requester waits. Exit to IDLE when Mx is granted with lock=0, when Mx drops req, or when the lock counter reaches MAX_LOCK (that grant is still performed, then forced IDLE).
  - Counter increments per granted access in OWNx; 8-bit, saturates, cleared in IDLE.
- After a forced release, the released requester has lowest priority for the next IDLE arbitration regardless of mode, guaranteeing the other side one slot.
- Requesters must hold addr/we/wdata/lock stable while req is high and gnt low.

## Timing
- Reset values: state IDLE, rvalid outputs 0, lock counter 0, round-robin pointer favours M0, forced-release flag 0. While rst=1, both gnt = 0 and ram_wea = 0.
- Grant: combinational from req, state, pointer; zero-cycle acceptance.
- Write: data in RAM at end of grant cycle. Read: rdata/rvalid one cycle after grant.
- Back-to-back reads from one requester: one word per cycle, rvalid continuous.
- Read from M1 in cycle N+1 of a write by M0 to same address in cycle N returns the new data (RAM write commits at edge N).
- Reset asserted with a read outstanding: rvalid forced 0 next cycle; the read is lost.

## Configuration
- BRAM_ARB_RR_EN defined: IDLE arbitration is round-robin; pointer toggles to the other requester after every IDLE grant.
- Not defined: fixed priority, M0 wins on contention (CPU never stalls behind the loader except inside an M1 lock); pointer logic removed. Forced-release rule applies in both builds.

## Structure
- Shared package bram_arb_pkg: state encoding (IDLE/OWN0/OWN1), requester index constants M0=0/M1=1, lock counter width.
- Optional sub-module bram_arb_pick: pure two-way priority selector (inputs req pair, priority bit; outputs one-hot grant), used in IDLE.
- Rest (FSM, lock counter, rvalid registers, muxes) in bram_arbiter top.

## Test plan
- Reset: hold rst 3 cycles with both req=1, we=4'hF → gnt both 0, ram_wea 0, rvalid 0 throughout.
- Single write/read: M0 writes 0xDEADBEEF to 0x0010 with we=4'hF, then reads 0x0010 → m0_rvalid=1 one cycle after the read grant, rdata=0xDEADBEEF; m1_rvalid stays 0.
- Byte enables: pre-write 0x11223344 to 0x0020, M1 writes 0xAABBCCDD with we=4'b0101 → readback 0x11BB33DD.
- Contention: both request every cycle for 8 cycles, no lock → RR build grants alternate M0,M1,M0,…; fixed build grants M0 all 8 cycles.
- Lock burst: MAX_LOCK=4, M1 lock=1 with 6 reads 0x0100..0x0105, M0 requesting throughout → M1 gets 4 consecutive grants, M0 gets next grant, then M1 resumes at 0x0104.
- Reset mid-read: M0 read granted cycle N, rst=1 cycle N+1 → m0_rvalid=0 in N+1 and after.
